// File: rtl/chr_sram_pkg.sv
// Shared definitions for the CHR SRAM arbiter and the CHR loader.
// Latency: none (types, constants and a pure address-mapping function).
// Backpressure: not applicable.
package chr_sram_pkg;

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_IDLE = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_ACK  = 3'd4
  } state_t;

  // Write cycle: setup, two strobe-low phases, hold.
  localparam int WR_PHASES = 4;

  typedef struct packed {
    logic [19:0] word;  // SRAM word address
    logic        lane;  // 1 = upper byte, 0 = lower byte
  } chr_map_t;

  // CPU byte address to SRAM word and byte lane. Bit 3 selects the lane so
  // that the two 8-byte tile planes land side by side in one 16-bit word.
  function automatic chr_map_t map_cpu_addr(input logic [19:0] byte_addr);
    chr_map_t m;
    m.word = {1'b0, byte_addr[19:4], byte_addr[2:0]};
    m.lane = byte_addr[3];
    return m;
  endfunction

endpackage

// File: rtl/chr_sram_prio_sel.sv
// Grant selection between PPU and CPU with a starvation guard for the CPU.
// Latency: grants are combinational; the streak counter updates on the sampling cycle.
// Backpressure: requesters hold their request until acked; no grant unless sample is high.
module chr_sram_prio_sel #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic ppu_req,
  input  logic cpu_req,
  output logic grant_ppu,
  output logic grant_cpu
);

  logic [7:0] streak;

  // PPU wins ties unless it has already beaten a waiting CPU STARVE_LIMIT times.
  always_comb begin
    grant_ppu = 1'b0;
    grant_cpu = 1'b0;
    if (sample) begin
      if (ppu_req && cpu_req) begin
        if (streak == 8'(STARVE_LIMIT)) grant_cpu = 1'b1;
        else                            grant_ppu = 1'b1;
      end else if (ppu_req) begin
        grant_ppu = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end
    end
  end

  // Count consecutive PPU wins over a waiting CPU; anything else clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (sample) begin
      if (grant_ppu && cpu_req) streak <= (streak == 8'hFF) ? streak : streak + 8'd1;
      else                      streak <= '0;
    end
  end

endmodule

// File: rtl/chr_sram_arbiter.sv
// CHR SRAM owner: loader passthrough during boot, then PPU/CPU arbitration onto the async SRAM.
// Latency: request seen in S_IDLE to ack is RD_WAIT+1 cycles for reads, 5 cycles for writes.
// Backpressure: requests are held until a one-cycle ack; one access in flight, PPU priority with CPU starvation guard.
module chr_sram_arbiter
  import chr_sram_pkg::*;
#(
  parameter int RD_WAIT          = 2,
  parameter int CPU_STARVE_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ldr_done,
  input  logic [19:0] i_ldr_addr,
  input  logic [15:0] i_ldr_wdata,
  input  logic        i_ldr_oe_n,
  input  logic        i_ldr_we_n,
  input  logic        i_ldr_ub_n,
  input  logic        i_ldr_lb_n,
  output logic        o_ready,
  input  logic        i_ppu_req,
  input  logic [18:0] i_ppu_addr,
  output logic        o_ppu_ack,
  output logic [15:0] o_ppu_rdata,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [19:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_ack,
  output logic [7:0]  o_cpu_rdata,
  output logic [19:0] o_sram_addr,
  output logic [15:0] o_sram_wdata,
  input  logic [15:0] i_sram_rdata,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n,
  output logic        o_sram_ub_n,
  output logic        o_sram_lb_n
);

  state_t      state_q, state_d;
  logic [3:0]  phase_q, phase_d;
  logic        own_ppu_q, own_ppu_d;
  logic        lane_q, lane_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        oe_n_q, we_n_q, ub_n_q, lb_n_q;
  logic        oe_n_d, we_n_d, ub_n_d, lb_n_d;
  logic        ppu_ack_q, cpu_ack_q, ppu_ack_d, cpu_ack_d;
  logic [15:0] ppu_rdata_q;
  logic [7:0]  cpu_rdata_q;
  logic        grant_ppu, grant_cpu;
  logic        rd_last;
  chr_map_t    cpu_map;

  assign cpu_map = map_cpu_addr(i_cpu_addr);
  assign rd_last = (state_q == S_RD) && (phase_q == 4'(RD_WAIT - 1));

  chr_sram_prio_sel #(
    .STARVE_LIMIT(CPU_STARVE_LIMIT)
  ) u_prio_sel (
    .clk       (i_clk),
    .rst       (i_rst),
    .sample    (state_q == S_IDLE),
    .ppu_req   (i_ppu_req),
    .cpu_req   (i_cpu_req),
    .grant_ppu (grant_ppu),
    .grant_cpu (grant_cpu)
  );

  // Next state, phase counter and the address/data latched for the access in flight.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    own_ppu_d = own_ppu_q;
    lane_d    = lane_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      S_BOOT: begin
        if (i_ldr_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        phase_d = '0;
        if (grant_ppu) begin
          state_d   = S_RD;
          own_ppu_d = 1'b1;
          lane_d    = 1'b0;
          addr_d    = {1'b0, i_ppu_addr};
          wdata_d   = '0;
        end else if (grant_cpu) begin
          state_d   = i_cpu_we ? S_WR : S_RD;
          own_ppu_d = 1'b0;
          lane_d    = cpu_map.lane;
          addr_d    = cpu_map.word;
          if (!i_cpu_we)         wdata_d = '0;
          else if (cpu_map.lane) wdata_d = {i_cpu_wdata, 8'h00};
          else                   wdata_d = {8'h00, i_cpu_wdata};
        end
      end
      S_RD: begin
        if (rd_last) begin
          state_d = S_ACK;
          phase_d = '0;
          addr_d  = '0;
          wdata_d = '0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      S_WR: begin
        if (phase_q == 4'(WR_PHASES - 1)) begin
          state_d = S_ACK;
          phase_d = '0;
          addr_d  = '0;
          wdata_d = '0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // Strobes and acks decoded from the next state so the SRAM pins come straight from flops.
  always_comb begin
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    ub_n_d    = 1'b1;
    lb_n_d    = 1'b1;
    ppu_ack_d = 1'b0;
    cpu_ack_d = 1'b0;
    case (state_d)
      S_RD: begin
        oe_n_d = 1'b0;
        ub_n_d = !(own_ppu_d || lane_d);
        lb_n_d = !(own_ppu_d || !lane_d);
      end
      S_WR: begin
        we_n_d = !((phase_d == 4'd1) || (phase_d == 4'd2));
        ub_n_d = !lane_d;
        lb_n_d = lane_d;
      end
      S_ACK: begin
        ppu_ack_d = own_ppu_d;
        cpu_ack_d = !own_ppu_d;
      end
      default: ;
    endcase
  end

  // State, access and pin registers; reset abandons any access without an ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_BOOT;
      phase_q   <= '0;
      own_ppu_q <= 1'b0;
      lane_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
      ppu_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      own_ppu_q <= own_ppu_d;
      lane_q    <= lane_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      ub_n_q    <= ub_n_d;
      lb_n_q    <= lb_n_d;
      ppu_ack_q <= ppu_ack_d;
      cpu_ack_q <= cpu_ack_d;
    end
  end

  // Capture read data on the last OE cycle; values hold until the owner's next read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ppu_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else if (rd_last) begin
      if (own_ppu_q)   ppu_rdata_q <= i_sram_rdata;
      else if (lane_q) cpu_rdata_q <= i_sram_rdata[15:8];
      else             cpu_rdata_q <= i_sram_rdata[7:0];
    end
  end

  // During boot the loader drives the SRAM directly.
  always_comb begin
    if (state_q == S_BOOT) begin
      o_sram_addr  = i_ldr_addr;
      o_sram_wdata = i_ldr_wdata;
      o_sram_oe_n  = i_ldr_oe_n;
      o_sram_we_n  = i_ldr_we_n;
      o_sram_ub_n  = i_ldr_ub_n;
      o_sram_lb_n  = i_ldr_lb_n;
    end else begin
      o_sram_addr  = addr_q;
      o_sram_wdata = wdata_q;
      o_sram_oe_n  = oe_n_q;
      o_sram_we_n  = we_n_q;
      o_sram_ub_n  = ub_n_q;
      o_sram_lb_n  = lb_n_q;
    end
  end

  assign o_ready     = (state_q != S_BOOT);
  assign o_ppu_ack   = ppu_ack_q;
  assign o_cpu_ack   = cpu_ack_q;
  assign o_ppu_rdata = ppu_rdata_q;
  assign o_cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_chr_sram_arbiter.sv
// Self-checking bench for chr_sram_arbiter with a behavioural async SRAM.
// Latency: checks RD_WAIT+1 read and 5-cycle write ack latency.
// Backpressure: requests held until ack; a scoreboard matches acks against expected order and data.
module tb_chr_sram_arbiter;
  import chr_sram_pkg::*;

  localparam int RD_WAIT = 2;
  localparam int LIMIT   = 8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_ldr_done;
  logic [19:0] i_ldr_addr;
  logic [15:0] i_ldr_wdata;
  logic        i_ldr_oe_n, i_ldr_we_n, i_ldr_ub_n, i_ldr_lb_n;
  logic        o_ready;
  logic        i_ppu_req;
  logic [18:0] i_ppu_addr;
  logic        o_ppu_ack;
  logic [15:0] o_ppu_rdata;
  logic        i_cpu_req, i_cpu_we;
  logic [19:0] i_cpu_addr;
  logic [7:0]  i_cpu_wdata;
  logic        o_cpu_ack;
  logic [7:0]  o_cpu_rdata;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_wdata;
  logic [15:0] i_sram_rdata;
  logic        o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n;

  chr_sram_arbiter #(.RD_WAIT(RD_WAIT), .CPU_STARVE_LIMIT(LIMIT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ldr_done(i_ldr_done),
    .i_ldr_addr(i_ldr_addr), .i_ldr_wdata(i_ldr_wdata),
    .i_ldr_oe_n(i_ldr_oe_n), .i_ldr_we_n(i_ldr_we_n),
    .i_ldr_ub_n(i_ldr_ub_n), .i_ldr_lb_n(i_ldr_lb_n),
    .o_ready(o_ready),
    .i_ppu_req(i_ppu_req), .i_ppu_addr(i_ppu_addr),
    .o_ppu_ack(o_ppu_ack), .o_ppu_rdata(o_ppu_rdata),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata),
    .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata),
    .o_sram_oe_n(o_sram_oe_n), .o_sram_we_n(o_sram_we_n),
    .o_sram_ub_n(o_sram_ub_n), .o_sram_lb_n(o_sram_lb_n)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural SRAM: combinational read while OE low, byte-lane writes while WE low.
  logic [15:0] mem [4096];
  assign i_sram_rdata = o_sram_oe_n ? 16'hDEAD : mem[o_sram_addr[11:0]];
  always @(posedge i_clk) begin
    if (i_rst) begin
      mem[12'h010] <= 16'h3C7E;
      mem[12'h020] <= 16'hBEEF;
    end else if (!o_sram_we_n) begin
      if (!o_sram_ub_n) mem[o_sram_addr[11:0]][15:8] <= o_sram_wdata[15:8];
      if (!o_sram_lb_n) mem[o_sram_addr[11:0]][7:0]  <= o_sram_wdata[7:0];
    end
  end

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: expected ack owner and read data, pushed when stimulus is driven.
  typedef struct {
    logic        is_ppu;
    logic        chk;
    logic [15:0] data;
  } sb_t;
  sb_t sb[$];

  always @(negedge i_clk) begin : monitor
    sb_t e;
    if (!i_rst && (o_ppu_ack || o_cpu_ack)) begin
      ack_cnt++;
      check("ack_onehot", {31'd0, o_ppu_ack & o_cpu_ack}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack ppu=%b cpu=%b required=no ack", o_ppu_ack, o_cpu_ack);
      end else begin
        e = sb.pop_front();
        check("sb_owner_ppu", {31'd0, o_ppu_ack}, {31'd0, e.is_ppu});
        if (e.chk) check("sb_rdata", o_ppu_ack ? {16'd0, o_ppu_rdata} : {24'd0, o_cpu_rdata},
                         {16'd0, e.data});
      end
    end
  end

  // Address/data must stay stable while a request is pending and unacked.
  assert property (@(posedge i_clk) disable iff (i_rst)
    (i_cpu_req && !o_cpu_ack) |=> (!i_cpu_req || ($stable(i_cpu_addr) && $stable(i_cpu_we) && $stable(i_cpu_wdata))));
  assert property (@(posedge i_clk) disable iff (i_rst)
    (i_ppu_req && !o_ppu_ack) |=> (!i_ppu_req || $stable(i_ppu_addr)));

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [19:0] exp_addr;
    logic        exp_ub_n;
    logic        exp_lb_n;
    logic [15:0] exp_wdata;
    logic [7:0]  exp_rdata;
  } vec_t;
  vec_t vecs [10];

  task automatic cpu_access(input vec_t v);
    int cyc, we_lo, oe_lo;
    logic done;
    logic [19:0] s_addr;
    logic s_ub, s_lb;
    logic [15:0] s_wd;
    sb_t e;
    @(posedge i_clk); #1;
    i_cpu_we = v.we; i_cpu_addr = v.addr; i_cpu_wdata = v.wdata; i_cpu_req = 1'b1;
    e.is_ppu = 1'b0; e.chk = !v.we; e.data = {8'h00, v.exp_rdata};
    sb.push_back(e);
    cyc = 0; we_lo = 0; oe_lo = 0; done = 1'b0;
    s_addr = '1; s_ub = 1'bx; s_lb = 1'bx; s_wd = 'x;
    while (!done && cyc < 40) begin
      @(posedge i_clk); cyc++;
      @(negedge i_clk);
      if (!o_sram_we_n) begin we_lo++; s_addr = o_sram_addr; s_ub = o_sram_ub_n; s_lb = o_sram_lb_n; s_wd = o_sram_wdata; end
      if (!o_sram_oe_n) begin oe_lo++; s_addr = o_sram_addr; s_ub = o_sram_ub_n; s_lb = o_sram_lb_n; end
      if (o_cpu_ack) done = 1'b1;
    end
    i_cpu_req = 1'b0;
    check("cpu_ack_latency", cyc, v.we ? 32'd5 : 32'(RD_WAIT + 1));
    check("cpu_sram_addr", {12'd0, s_addr}, {12'd0, v.exp_addr});
    check("cpu_ub_n", {31'd0, s_ub}, {31'd0, v.exp_ub_n});
    check("cpu_lb_n", {31'd0, s_lb}, {31'd0, v.exp_lb_n});
    if (v.we) begin
      check("cpu_we_low_cycles", we_lo, 32'd2);
      check("cpu_wr_oe_cycles", oe_lo, 32'd0);
      check("cpu_sram_wdata", {16'd0, s_wd}, {16'd0, v.exp_wdata});
    end else begin
      check("cpu_oe_low_cycles", oe_lo, 32'(RD_WAIT));
      check("cpu_rd_we_cycles", we_lo, 32'd0);
    end
  endtask

  task automatic ppu_read(input logic [18:0] a, input logic [15:0] exp);
    int cyc, oe_lo;
    logic done;
    logic [19:0] s_addr;
    logic s_ub, s_lb;
    sb_t e;
    @(posedge i_clk); #1;
    i_ppu_addr = a; i_ppu_req = 1'b1;
    e.is_ppu = 1'b1; e.chk = 1'b1; e.data = exp;
    sb.push_back(e);
    cyc = 0; oe_lo = 0; done = 1'b0; s_addr = '1; s_ub = 1'bx; s_lb = 1'bx;
    while (!done && cyc < 40) begin
      @(posedge i_clk); cyc++;
      @(negedge i_clk);
      if (!o_sram_oe_n) begin oe_lo++; s_addr = o_sram_addr; s_ub = o_sram_ub_n; s_lb = o_sram_lb_n; end
      if (o_ppu_ack) done = 1'b1;
    end
    i_ppu_req = 1'b0;
    check("ppu_ack_latency", cyc, 32'(RD_WAIT + 1));
    check("ppu_oe_low_cycles", oe_lo, 32'(RD_WAIT));
    check("ppu_sram_addr", {12'd0, s_addr}, {13'd0, a});
    check("ppu_ub_lb_n", {30'd0, s_ub, s_lb}, 32'd0);
  endtask

  task automatic push_exp(input logic is_ppu, input logic [15:0] d);
    sb_t e;
    e.is_ppu = is_ppu; e.chk = 1'b1; e.data = d;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc, ppu_before, cpu_seen, acks0;
    int order [2];

    vecs[0] = '{1'b1, 20'h0000B, 8'hA5, 20'h00003, 1'b0, 1'b1, 16'hA500, 8'h00};
    vecs[1] = '{1'b1, 20'h00003, 8'h5A, 20'h00003, 1'b1, 1'b0, 16'h005A, 8'h00};
    vecs[2] = '{1'b1, 20'h00017, 8'hC3, 20'h0000F, 1'b1, 1'b0, 16'h00C3, 8'h00};
    vecs[3] = '{1'b1, 20'h0001F, 8'h3C, 20'h0000F, 1'b0, 1'b1, 16'h3C00, 8'h00};
    vecs[4] = '{1'b1, 20'hFFFF8, 8'h77, 20'h7FFF8, 1'b0, 1'b1, 16'h7700, 8'h00};
    vecs[5] = '{1'b0, 20'h0000B, 8'h00, 20'h00003, 1'b0, 1'b1, 16'h0000, 8'hA5};
    vecs[6] = '{1'b0, 20'h00003, 8'h00, 20'h00003, 1'b1, 1'b0, 16'h0000, 8'h5A};
    vecs[7] = '{1'b0, 20'h00017, 8'h00, 20'h0000F, 1'b1, 1'b0, 16'h0000, 8'hC3};
    vecs[8] = '{1'b0, 20'h0001F, 8'h00, 20'h0000F, 1'b0, 1'b1, 16'h0000, 8'h3C};
    vecs[9] = '{1'b0, 20'hFFFF8, 8'h00, 20'h7FFF8, 1'b0, 1'b1, 16'h0000, 8'h77};

    i_rst = 1'b1; i_ldr_done = 1'b0; i_ldr_addr = '0; i_ldr_wdata = '0;
    i_ldr_oe_n = 1'b1; i_ldr_we_n = 1'b1; i_ldr_ub_n = 1'b1; i_ldr_lb_n = 1'b1;
    i_ppu_req = 1'b0; i_ppu_addr = '0; i_cpu_req = 1'b0; i_cpu_we = 1'b0;
    i_cpu_addr = '0; i_cpu_wdata = '0;

    // Reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_acks", {30'd0, o_ppu_ack, o_cpu_ack}, 32'd0);
    check("rst_rdata", {8'd0, o_ppu_rdata, o_cpu_rdata}, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Boot passthrough with a CPU request that must not be served
    i_ldr_addr = 20'h00123; i_ldr_wdata = 16'h1234;
    i_cpu_we = 1'b0; i_cpu_addr = 20'h0000B; i_cpu_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_ldr_we_n = k[0];
      @(negedge i_clk);
      check("boot_addr", {12'd0, o_sram_addr}, 32'h00123);
      check("boot_we_n", {31'd0, o_sram_we_n}, {31'd0, k[0]});
      check("boot_ready", {31'd0, o_ready}, 32'd0);
      @(posedge i_clk); #1;
    end
    i_ldr_we_n = 1'b1;
    check("boot_wdata", {16'd0, o_sram_wdata}, 32'h1234);
    check("boot_no_ack", ack_cnt, 32'd0);
    i_cpu_req = 1'b0; i_ldr_done = 1'b1;
    @(negedge i_clk);
    check("boot_ready_before", {31'd0, o_ready}, 32'd0);
    @(posedge i_clk); #1;
    i_ldr_done = 1'b0; i_ldr_we_n = 1'b0;
    @(negedge i_clk);
    check("boot_ready_after", {31'd0, o_ready}, 32'd1);
    check("ldr_ignored_we_n", {31'd0, o_sram_we_n}, 32'd1);
    check("ldr_ignored_addr", {12'd0, o_sram_addr}, 32'd0);
    i_ldr_we_n = 1'b1;

    // CPU writes then read-backs
    for (int i = 0; i < 10; i++) cpu_access(vecs[i]);

    // PPU word read
    ppu_read(19'h00010, 16'h3C7E);

    // Simultaneous first requests: PPU first, CPU next
    @(posedge i_clk); #1;
    push_exp(1'b1, 16'h3C7E);
    push_exp(1'b0, 16'h005A);
    i_ppu_addr = 19'h00010; i_cpu_we = 1'b0; i_cpu_addr = 20'h00003;
    i_ppu_req = 1'b1; i_cpu_req = 1'b1;
    n = 0; cyc = 0; order[0] = -1; order[1] = -1;
    while (n < 2 && cyc < 60) begin
      @(posedge i_clk); cyc++;
      @(negedge i_clk);
      if (o_ppu_ack) begin i_ppu_req = 1'b0; order[n] = 0; n++; end
      else if (o_cpu_ack) begin i_cpu_req = 1'b0; order[n] = 1; n++; end
    end
    i_ppu_req = 1'b0; i_cpu_req = 1'b0;
    check("simul_first_ppu", order[0], 32'd0);
    check("simul_second_cpu", order[1], 32'd1);
    check("ppu_rdata_held", {16'd0, o_ppu_rdata}, 32'h3C7E);

    // Starvation guard: LIMIT PPU acks, one CPU ack, then PPU again
    @(posedge i_clk); #1;
    for (int k = 0; k < LIMIT; k++) push_exp(1'b1, 16'hBEEF);
    push_exp(1'b0, 16'h00A5);
    push_exp(1'b1, 16'hBEEF);
    push_exp(1'b1, 16'hBEEF);
    i_ppu_addr = 19'h00020; i_cpu_we = 1'b0; i_cpu_addr = 20'h0000B;
    i_ppu_req = 1'b1; i_cpu_req = 1'b1;
    n = 0; cyc = 0; ppu_before = 0; cpu_seen = 0;
    while (n < LIMIT + 3 && cyc < 300) begin
      @(posedge i_clk); cyc++;
      @(negedge i_clk);
      if (o_ppu_ack) begin n++; if (cpu_seen == 0) ppu_before++; end
      if (o_cpu_ack) begin n++; cpu_seen++; i_cpu_req = 1'b0; end
    end
    i_ppu_req = 1'b0; i_cpu_req = 1'b0;
    check("starve_ppu_before_cpu", ppu_before, 32'(LIMIT));
    check("starve_cpu_acks", cpu_seen, 32'd1);
    check("starve_total_acks", n, 32'(LIMIT + 3));

    // Reset in write phase 1
    @(posedge i_clk); #1;
    i_cpu_we = 1'b1; i_cpu_addr = 20'h0000B; i_cpu_wdata = 8'h11; i_cpu_req = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    check("midwr_we_low", {31'd0, o_sram_we_n}, 32'd0);
    acks0 = ack_cnt;
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check("midwr_we_n_after_rst", {31'd0, o_sram_we_n}, 32'd1);
    check("midwr_ready", {31'd0, o_ready}, 32'd0);
    check("midwr_state", {29'd0, dut.state_q}, {29'd0, S_BOOT});
    i_cpu_req = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    check("midwr_no_ack", ack_cnt, acks0);
    check("midwr_still_boot", {31'd0, o_ready}, 32'd0);
    @(posedge i_clk); #1;
    i_ldr_done = 1'b1;
    @(posedge i_clk); #1;
    i_ldr_done = 1'b0;
    cpu_access(vecs[7]);

    repeat (3) @(negedge i_clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
